// File: rtl/pipe_phy_cmd_responder.sv
// rtl/pipe_phy_cmd_responder.sv - per-lane PIPE PHY responder for detect/powerdown/rate commands
module pipe_phy_cmd_responder #(
    parameter int RESET_CYCLES  = 16,
    parameter int DETECT_CYCLES = 40,
    parameter int PD_CYCLES     = 8,
    parameter int RATE_CYCLES   = 24
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       txdetectrx,
    input  logic       txelecidle,
    input  logic [2:0] powerdown,
    input  logic [1:0] rate,
    input  logic       rx_present,
    output logic       phystatus,
    output logic [2:0] rxstatus,
    output logic [2:0] cur_powerdown,
    output logic [1:0] cur_rate,
    output logic       busy,
    output logic       invalid_req
);

    localparam int MAX_AB     = (DETECT_CYCLES > PD_CYCLES) ? DETECT_CYCLES : PD_CYCLES;
    localparam int MAX_CD     = (RATE_CYCLES > RESET_CYCLES) ? RATE_CYCLES : RESET_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam int RST_LAST_I = RESET_CYCLES - 1;
    localparam logic [CW-1:0] RST_LAST  = RST_LAST_I[CW-1:0];
    localparam logic [CW-1:0] PD_LAST   = PD_CYCLES[CW-1:0];
    localparam logic [CW-1:0] RATE_LAST = RATE_CYCLES[CW-1:0];
    localparam logic [CW-1:0] DET_LAST  = DETECT_CYCLES[CW-1:0];

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        PD_CHG,
        RATE_CHG,
        DETECT,
        STATUS
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    pd_tgt, pd_tgt_d;
    logic [1:0]    rate_tgt, rate_tgt_d;
    logic [2:0]    cur_pd_d;
    logic [1:0]    cur_rate_d;
    logic [2:0]    rxstatus_d;
    logic          det_armed, det_armed_d;
    logic          pd_ill, rate_ill, pd_ill_q, rate_ill_q;

    assign pd_ill   = (powerdown > 3'd3);
    assign rate_ill = (rate == 2'd3);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pd_tgt_d    = pd_tgt;
        rate_tgt_d  = rate_tgt;
        cur_pd_d    = cur_powerdown;
        cur_rate_d  = cur_rate;
        rxstatus_d  = 3'b000;
        det_armed_d = det_armed | ~txdetectrx;
        case (state)
            RST_WAIT: begin
                cnt_d = cnt + 1'b1;
                if (cnt == RST_LAST) state_d = IDLE;
            end
            IDLE: begin
                if (powerdown != cur_powerdown && !pd_ill) begin
                    pd_tgt_d = powerdown;
                    state_d  = PD_CHG;
                end else if (rate != cur_rate && !rate_ill && cur_powerdown <= 3'd1) begin
                    rate_tgt_d = rate;
                    state_d    = RATE_CHG;
                end else if (txdetectrx && txelecidle && det_armed && cur_powerdown == 3'd2) begin
                    det_armed_d = 1'b0;
                    state_d     = DETECT;
                end
            end
            PD_CHG: begin
                cnt_d = cnt + 1'b1;
                if (cnt == PD_LAST) begin
                    cur_pd_d = pd_tgt;
                    state_d  = STATUS;
                end
            end
            RATE_CHG: begin
                cnt_d = cnt + 1'b1;
                if (cnt == RATE_LAST) begin
                    cur_rate_d = rate_tgt;
                    state_d    = STATUS;
                end
            end
            DETECT: begin
                cnt_d = cnt + 1'b1;
                if (cnt == DET_LAST) begin
                    rxstatus_d = rx_present ? 3'b011 : 3'b000;
                    state_d    = STATUS;
                end
            end
            STATUS:  state_d = IDLE;
            default: state_d = RST_WAIT;
        endcase
        // Counter restarts on every state entry so it can never wrap.
        if (state_d != state) cnt_d = '0;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RST_WAIT;
            cnt           <= '0;
            pd_tgt        <= 3'd2;
            rate_tgt      <= 2'd0;
            det_armed     <= 1'b1;
            pd_ill_q      <= 1'b0;
            rate_ill_q    <= 1'b0;
            phystatus     <= 1'b1;
            rxstatus      <= 3'b000;
            cur_powerdown <= 3'd2;
            cur_rate      <= 2'd0;
            busy          <= 1'b1;
            invalid_req   <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            pd_tgt        <= pd_tgt_d;
            rate_tgt      <= rate_tgt_d;
            det_armed     <= det_armed_d;
            pd_ill_q      <= pd_ill;
            rate_ill_q    <= rate_ill;
            phystatus     <= (state_d == STATUS) || (state_d == RST_WAIT);
            rxstatus      <= rxstatus_d;
            cur_powerdown <= cur_pd_d;
            cur_rate      <= cur_rate_d;
            busy          <= (state_d != IDLE);
            invalid_req   <= (pd_ill & ~pd_ill_q) | (rate_ill & ~rate_ill_q);
        end
    end

endmodule

// File: tb/tb_pipe_phy_cmd_responder.sv
// tb/tb_pipe_phy_cmd_responder.sv - randomized bench with a timeline model of the responder
module tb_pipe_phy_cmd_responder;

    localparam int RESET_CYCLES  = 16;
    localparam int DETECT_CYCLES = 40;
    localparam int PD_CYCLES     = 8;
    localparam int RATE_CYCLES   = 24;

    logic       pclk = 1'b0;
    logic       reset_n;
    logic       txdetectrx;
    logic       txelecidle;
    logic [2:0] powerdown;
    logic [1:0] rate;
    logic       rx_present;
    logic       phystatus;
    logic [2:0] rxstatus;
    logic [2:0] cur_powerdown;
    logic [1:0] cur_rate;
    logic       busy;
    logic       invalid_req;

    pipe_phy_cmd_responder #(
        .RESET_CYCLES (RESET_CYCLES),
        .DETECT_CYCLES(DETECT_CYCLES),
        .PD_CYCLES    (PD_CYCLES),
        .RATE_CYCLES  (RATE_CYCLES)
    ) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .txdetectrx   (txdetectrx),
        .txelecidle   (txelecidle),
        .powerdown    (powerdown),
        .rate         (rate),
        .rx_present   (rx_present),
        .phystatus    (phystatus),
        .rxstatus     (rxstatus),
        .cur_powerdown(cur_powerdown),
        .cur_rate     (cur_rate),
        .busy         (busy),
        .invalid_req  (invalid_req)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: edge-indexed timeline of the current command and the PHY's visible state
    int t, rst_k, pulse_edge, next_decide, kind;
    int m_pd, m_rate, tgt_pd, tgt_rate;
    bit m_armed, m_pi, m_ri;
    int e_phy, e_rxs, e_busy, e_inv;

    task automatic model_reset();
        t = 0; rst_k = 0; pulse_edge = -1; next_decide = 0; kind = 0;
        m_pd = 2; m_rate = 0; tgt_pd = 2; tgt_rate = 0;
        m_armed = 1'b1; m_pi = 1'b0; m_ri = 1'b0;
        e_phy = 1; e_rxs = 0; e_busy = 1; e_inv = 0;
    endtask

    task automatic model_step();
        bit pi, ri, started;
        t++;
        pi = (powerdown > 3);
        ri = (rate == 3);
        e_inv = ((pi && !m_pi) || (ri && !m_ri)) ? 1 : 0;
        m_pi = pi;
        m_ri = ri;
        started = 1'b0;
        if (rst_k < RESET_CYCLES) begin
            rst_k++;
            if (rst_k == RESET_CYCLES) begin
                e_phy = 0; e_busy = 0; next_decide = t + 1;
            end
        end else if (pulse_edge >= 0) begin
            if (t == pulse_edge) begin
                e_phy = 1;
                if (kind == 0) m_pd = tgt_pd;
                else if (kind == 1) m_rate = tgt_rate;
                else e_rxs = rx_present ? 3 : 0;
            end else if (t == pulse_edge + 1) begin
                e_phy = 0; e_rxs = 0; e_busy = 0;
                pulse_edge = -1;
                next_decide = t + 1;
            end
        end else if (t >= next_decide) begin
            if (int'(powerdown) != m_pd && !pi) begin
                kind = 0; tgt_pd = powerdown; pulse_edge = t + PD_CYCLES + 1;
            end else if (int'(rate) != m_rate && !ri && m_pd <= 1) begin
                kind = 1; tgt_rate = rate; pulse_edge = t + RATE_CYCLES + 1;
            end else if (txdetectrx && txelecidle && m_armed && m_pd == 2) begin
                kind = 2; started = 1'b1; pulse_edge = t + DETECT_CYCLES + 1;
            end
            if (pulse_edge >= 0) e_busy = 1;
        end
        if (!txdetectrx) m_armed = 1'b1;
        else if (started) m_armed = 1'b0;
    endtask

    task automatic compare_all();
        chk("phystatus", phystatus, e_phy);
        chk("rxstatus", rxstatus, e_rxs);
        chk("busy", busy, e_busy);
        chk("invalid_req", invalid_req, e_inv);
        chk("cur_powerdown", cur_powerdown, m_pd);
        chk("cur_rate", cur_rate, m_rate);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            model_step();
            @(negedge pclk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge pclk);
        @(negedge pclk);
        compare_all();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b1;
        txdetectrx = 1'b0;
        txelecidle = 1'b1;
        powerdown  = 3'd2;
        rate       = 2'd0;
        rx_present = 1'b0;
        @(negedge pclk);
        do_reset();
        run(20);

        // Detect with receiver present, held request must not retrigger
        rx_present = 1'b1; txdetectrx = 1'b1; run(60);
        txdetectrx = 1'b0; run(2);
        rx_present = 1'b0; txdetectrx = 1'b1; run(50);
        txdetectrx = 1'b0; run(2);

        // P1 -> P0, then rate 0 -> 2
        powerdown = 3'd0; run(12);
        rate = 2'd2; run(30);

        // Back to P1, then powerdown and rate together
        powerdown = 3'd2; run(12);
        powerdown = 3'd0; rate = 2'd1; run(50);

        // Illegal values
        powerdown = 3'd5; run(4);
        powerdown = 3'd0; rate = 2'd3; run(4);
        rate = 2'd1; run(3);
        powerdown = 3'd7; run(3);
        powerdown = 3'd0; run(3);

        // Abort in the middle of a detect
        powerdown = 3'd2; run(12);
        rx_present = 1'b1; txdetectrx = 1'b1; run(20);
        do_reset();
        run(70);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int r;
                r = $urandom_range(0, 15);
                powerdown = (r < 12) ? 3'(r % 4) : 3'(4 + r % 4);
            end
            if ($urandom_range(0, 19) == 0) rate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) txdetectrx = ~txdetectrx;
            if ($urandom_range(0, 9) == 0) txelecidle = ~txelecidle;
            if ($urandom_range(0, 7) == 0) rx_present = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1499) == 0) begin
                @(negedge pclk);
                do_reset();
            end
            run(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
